// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, the NOP word
// and the default reset fetch address.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding, word goes to IF/ID or hold
    ST_HOLD  = 2'd1,  // no request, fetched word parked while decode stalls
    ST_DROP  = 2'd2   // request outstanding whose word will be thrown away
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: flush > stall > load > bubble.
// A bubble clears valid and forces the NOP word; pcplus4 is left as-is on a
// bubble because nothing downstream reads it while valid_d=0.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pcplus4_in,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);

  // IF/ID contents update with flush/stall/load enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d   <= NOP;
      pcplus4_d <= 32'h0;
      valid_d   <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (stall) begin
      instr_d   <= instr_d;
      pcplus4_d <= pcplus4_d;
      valid_d   <= valid_d;
    end else if (load) begin
      instr_d   <= instr_in;
      pcplus4_d <= pcplus4_in;
      valid_d   <= 1'b1;
    end else begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives one instruction-memory request at a time,
// parks a returned word while decode stalls, and discards words belonging to
// a request that a redirect made stale.
//
// Handshake: imem_req/imem_addr are a request that stays stable until the
// cycle imem_ack=1 (ack may arrive in the request cycle); imem_rdata is only
// sampled when imem_req & imem_ack. At most one request is outstanding.
//
// Optional build macro FETCH_PERF_CNT_EN adds the fetched_cnt output, which
// counts every word written into IF/ID as a valid instruction.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetched_cnt,
`endif
  output logic [1:0]  state_dbg
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_f, pc_n;
  logic [31:0]  hold_instr, hold_instr_n;
  logic [31:0]  hold_pc4, hold_pc4_n;
  logic [31:0]  redir_pc, redir_pc_n;
  logic         ifid_load;
  logic [31:0]  ifid_instr, ifid_pc4;
  logic         got_word;
  logic [31:0]  pc_plus4;

  assign got_word  = imem_req & imem_ack;
  assign pc_plus4  = pc_f + 32'd4;
  assign imem_req  = (state != ST_HOLD);
  assign imem_addr = pc_f;
  assign state_dbg = state;

  // Fetch state, pc and side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc_f       <= RESET_PC;
      hold_instr <= NOP;
      hold_pc4   <= 32'h0;
      redir_pc   <= 32'h0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      hold_instr <= hold_instr_n;
      hold_pc4   <= hold_pc4_n;
      redir_pc   <= redir_pc_n;
    end
  end

  // Next-state, next-pc and IF/ID write selection; redirect wins over all
  always_comb begin
    state_n      = state;
    pc_n         = pc_f;
    hold_instr_n = hold_instr;
    hold_pc4_n   = hold_pc4;
    redir_pc_n   = redir_pc;
    ifid_load    = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc4     = pc_plus4;
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          if (got_word) begin
            pc_n = redirect_pc;
          end else begin
            redir_pc_n = redirect_pc;
            state_n    = ST_DROP;
          end
        end else if (got_word) begin
          pc_n = pc_plus4;
          if (stall) begin
            hold_instr_n = imem_rdata;
            hold_pc4_n   = pc_plus4;
            state_n      = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = ST_FETCH;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_instr;
          ifid_pc4   = hold_pc4;
          state_n    = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          redir_pc_n = redirect_pc;
        end
        if (got_word) begin
          pc_n    = redirect ? redirect_pc : redir_pc;
          state_n = ST_FETCH;
        end
      end
      default: begin
        state_n = ST_FETCH;
      end
    endcase
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .load       (ifid_load),
    .instr_in   (ifid_instr),
    .pcplus4_in (ifid_pc4),
    .instr_d    (instr_d),
    .pcplus4_d  (pcplus4_d),
    .valid_d    (valid_d)
  );

`ifdef FETCH_PERF_CNT_EN
  logic cnt_inc;
  assign cnt_inc = ifid_load & ~flush & ~stall;

  // Count words that land in IF/ID as valid instructions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_cnt <= 32'h0;
    end else if (cnt_inc) begin
      fetched_cnt <= fetched_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pcplus4_d;
  logic        valid_d;
  logic [1:0]  state_dbg;

  logic        req2;
  logic [31:0] addr2, instr2, pc4_2;
  logic        valid2;
  logic [1:0]  state2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt, cnt2;
`endif

  int total = 0;
  int bad   = 0;

  // clock
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_d(instr_d),
    .pcplus4_d(pcplus4_d), .valid_d(valid_d),
`ifdef FETCH_PERF_CNT_EN
    .fetched_cnt(fetched_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // second instance only to observe the address wrap from the top of memory
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(32'h1234_5678), .stall(1'b0), .flush(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0), .instr_d(instr2),
    .pcplus4_d(pc4_2), .valid_d(valid2),
`ifdef FETCH_PERF_CNT_EN
    .fetched_cnt(cnt2),
`endif
    .state_dbg(state2)
  );

  // ---------------- reference model ----------------
  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] m_pc;
  bit          m_parked;         // a word is waiting for decode
  logic [31:0] m_park_word, m_park_pc4;
  bit          m_dropping;       // outstanding request is stale
  logic [31:0] m_target;
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_parked = 0; m_dropping = 0;
    m_park_word = 0; m_park_pc4 = 0; m_target = 0;
    m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
  endtask

  // one clock edge of the front end, given this cycle's inputs
  task automatic model_edge(input bit a, input bit s, input bit f,
                            input bit r, input logic [31:0] rp);
    bit          deliver = 0;
    logic [31:0] d_word = 0, d_pc4 = 0;
    bit          acked = a && !m_parked;
    if (m_parked) begin
      if (r) begin
        m_parked = 0; m_pc = rp;
      end else if (!s) begin
        deliver = 1; d_word = m_park_word; d_pc4 = m_park_pc4; m_parked = 0;
      end
    end else if (m_dropping) begin
      if (r) m_target = rp;
      if (acked) begin
        m_pc = m_target; m_dropping = 0;
      end
    end else if (r) begin
      if (acked) m_pc = rp;
      else begin m_dropping = 1; m_target = rp; end
    end else if (acked) begin
      d_word = memf(m_pc); d_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      if (s) begin
        m_parked = 1; m_park_word = d_word; m_park_pc4 = d_pc4;
      end else begin
        deliver = 1;
      end
    end
    if (f) begin
      m_valid = 0; m_instr = 0;
    end else if (!s) begin
      if (deliver) begin
        m_valid = 1; m_instr = d_word; m_pc4 = d_pc4; m_cnt = m_cnt + 1;
      end else begin
        m_valid = 0; m_instr = 0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'h0, imem_req}, {31'h0, !m_parked});
    if (!m_parked) chk("imem_addr", imem_addr, m_pc);
    chk("valid_d", {31'h0, valid_d}, {31'h0, m_valid});
    chk("instr_d", instr_d, m_instr);
    if (m_valid) chk("pcplus4_d", pcplus4_d, m_pc4);
`ifdef FETCH_PERF_CNT_EN
    chk("fetched_cnt", fetched_cnt, m_cnt);
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    imem_ack = 0; imem_rdata = 0; stall = 0; flush = 0;
    redirect = 0; redirect_pc = 0;
  endtask

  // check current outputs, apply inputs for the coming edge, advance model
  task automatic step(input bit a, input bit s, input bit f,
                      input bit r, input logic [31:0] rp);
    @(negedge clk);
    check_outputs();
    imem_ack    = a;
    imem_rdata  = memf(m_pc);
    stall       = s;
    flush       = f;
    redirect    = r;
    redirect_pc = rp;
    model_edge(a, s, f, r, rp);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {31'h0, valid_d}, 32'h0);
    chk({tag, "_instr"}, instr_d, 32'h0);
    chk({tag, "_pc4"}, pcplus4_d, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_cnt"}, fetched_cnt, 32'h0);
`endif
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_next_addr", addr2, 32'h0000_0000);
    chk("wrap_pcplus4", pc4_2, 32'h0000_0000);
    chk("wrap_valid", {31'h0, valid2}, 32'h1);
    chk("wrap_instr", instr2, 32'h1234_5678);

    // back-to-back fetch 0x0..0xC
    repeat (4) step(1, 0, 0, 0, 0);
    // slow memory at 0x10: two cycles without ack
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    // decode stalls while 0x20 returns, then releases
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (7) step(1, 0, 0, 0, 0);
    // redirect to 0x100 while 0x40 is still unacked
    step(0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    // redirect + flush in the ack cycle
    step(1, 0, 1, 1, 32'h200);
    repeat (2) step(1, 0, 0, 0, 0);
    // redirect while parked, and a second redirect during a drop
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'h300);
    step(0, 0, 0, 1, 32'h400);
    step(0, 0, 0, 1, 32'h500);
    step(1, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    // wrap from the top of memory on the main instance
    step(1, 0, 0, 1, 32'hFFFF_FFF8);
    repeat (3) step(1, 0, 0, 0, 0);

    // randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           {$urandom(), 2'b00} >> 0 & 32'hFFFF_FFFC);
      if (i == 300) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
